// File: rtl/peak_search_ctrl_if.sv
// Stream bundle for the peak search controller: metric input stream and
// {peak_metric, peak_index} report output stream.
interface peak_search_ctrl_if #(
  parameter int IN_DW      = 32,
  parameter int SEARCH_LEN = 4096
);
  localparam int IW = $clog2(SEARCH_LEN);

  logic [IN_DW-1:0]    s_axis_in_tdata;
  logic                s_axis_in_tvalid;
  logic [IN_DW+IW-1:0] m_axis_out_tdata;
  logic                m_axis_out_tvalid;
  logic                m_axis_out_tready;

  // master: metric source and report sink; slave: the controller itself
  modport master (
    output s_axis_in_tdata, s_axis_in_tvalid, m_axis_out_tready,
    input  m_axis_out_tdata, m_axis_out_tvalid
  );
  modport slave (
    input  s_axis_in_tdata, s_axis_in_tvalid, m_axis_out_tready,
    output m_axis_out_tdata, m_axis_out_tvalid
  );
endinterface

// File: rtl/peak_search_ctrl.sv
// Sequencer around the sync-metric peak detector: flush, warm-up, bounded search,
// hold-off refinement to the local maximum, and {metric, index} reporting.
module peak_search_ctrl #(
  parameter int IN_DW       = 32,
  parameter int WINDOW_LEN  = 8,
  parameter int SEARCH_LEN  = 4096,
  parameter int HOLDOFF_LEN = 64,
  parameter int CONTINUOUS  = 0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic abort_i,
  input  logic peak_detected_i,
  output logic det_reset_no,
  output logic busy_o,
  output logic timeout_o,
  peak_search_ctrl_if.slave bus
);
  localparam int IW = $clog2(SEARCH_LEN);
  localparam int WW = $clog2(WINDOW_LEN + 1) + 1;
  localparam int HW = $clog2(HOLDOFF_LEN) + 1;

  typedef enum logic [2:0] {IDLE, FLUSH, WARMUP, SEARCH, HOLDOFF, REPORT} state_t;

  state_t           state;
  logic [IN_DW-1:0] d_metric;
  logic [IN_DW-1:0] best_metric;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    d_idx;
  logic [IW-1:0]    best_idx;
  logic             flush_cnt;
  logic [WW-1:0]    warm_cnt;
  logic [HW-1:0]    hold_cnt;

  logic             beat;
  logic             idx_last;
  logic [IW-1:0]    idx_nxt;
  logic             upd;
  logic [IN_DW-1:0] nb_metric;
  logic [IW-1:0]    nb_idx;

  always_comb begin
    beat      = bus.s_axis_in_tvalid;
    idx_last  = (idx == IW'(SEARCH_LEN - 1));
    idx_nxt   = idx_last ? '0 : idx + 1'b1;
    // strict compare keeps the earliest index on ties
    upd       = (d_metric > best_metric);
    nb_metric = upd ? d_metric : best_metric;
    nb_idx    = upd ? d_idx : best_idx;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state                 <= IDLE;
      det_reset_no          <= 1'b0;
      busy_o                <= 1'b0;
      timeout_o             <= 1'b0;
      bus.m_axis_out_tvalid <= 1'b0;
      bus.m_axis_out_tdata  <= '0;
      d_metric              <= '0;
      d_idx                 <= '0;
      best_metric           <= '0;
      best_idx              <= '0;
      idx                   <= '0;
      flush_cnt             <= 1'b0;
      warm_cnt              <= '0;
      hold_cnt              <= '0;
    end else if (abort_i) begin
      state                 <= IDLE;
      det_reset_no          <= 1'b0;
      busy_o                <= 1'b0;
      timeout_o             <= 1'b0;
      bus.m_axis_out_tvalid <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      // one-beat delay so the sample lines up with the detector flag
      if (beat) begin
        d_metric <= bus.s_axis_in_tdata;
        d_idx    <= idx;
      end
      case (state)
        IDLE: begin
          det_reset_no <= 1'b0;
          if (start_i) begin
            state     <= FLUSH;
            busy_o    <= 1'b1;
            flush_cnt <= 1'b0;
            idx       <= '0;
          end
        end
        FLUSH: begin
          if (flush_cnt) begin
            det_reset_no <= 1'b1;
            warm_cnt     <= '0;
            state        <= WARMUP;
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        WARMUP: begin
          if (beat) begin
            if (warm_cnt == WW'(WINDOW_LEN)) begin
              idx   <= '0;
              state <= SEARCH;
            end else begin
              warm_cnt <= warm_cnt + 1'b1;
            end
          end
        end
        SEARCH: begin
          if (beat) begin
            idx <= idx_nxt;
            if (peak_detected_i) begin
              best_metric <= d_metric;
              best_idx    <= d_idx;
              hold_cnt    <= '0;
              state       <= HOLDOFF;
            end else if (idx_last) begin
              timeout_o    <= 1'b1;
              det_reset_no <= 1'b0;
              busy_o       <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        HOLDOFF: begin
          if (beat) begin
            idx         <= idx_nxt;
            best_metric <= nb_metric;
            best_idx    <= nb_idx;
            hold_cnt    <= hold_cnt + 1'b1;
            // report carries this beat's refinement, so load from the next-best values
            if (hold_cnt == HW'(HOLDOFF_LEN - 1) || idx_last) begin
              bus.m_axis_out_tvalid <= 1'b1;
              bus.m_axis_out_tdata  <= {nb_metric, nb_idx};
              state                 <= REPORT;
            end
          end
        end
        REPORT: begin
          if (beat) begin
            idx <= idx_nxt;
          end
          if (bus.m_axis_out_tready) begin
            bus.m_axis_out_tvalid <= 1'b0;
            if (CONTINUOUS != 0) begin
              state <= SEARCH;
            end else begin
              det_reset_no <= 1'b0;
              busy_o       <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_peak_search_ctrl.sv
// Scoreboard bench for peak_search_ctrl: a beat-indexed reference model predicts
// reports and timeouts; a negedge monitor pops and compares them.
module tb_peak_search_ctrl;
  localparam int IN_DW      = 32;
  localparam int WINDOW_LEN = 8;
  localparam int SL         = 512;
  localparam int H          = 64;
  localparam int IW         = $clog2(SL);
  localparam int NB         = 4 * SL;

  logic clk = 1'b0;
  logic reset, start, abort, peak;
  logic det_reset_no, busy, timeout;

  always #5 clk = ~clk;

  peak_search_ctrl_if #(.IN_DW(IN_DW), .SEARCH_LEN(SL)) bus ();

  peak_search_ctrl #(
    .IN_DW(IN_DW), .WINDOW_LEN(WINDOW_LEN), .SEARCH_LEN(SL),
    .HOLDOFF_LEN(H), .CONTINUOUS(1)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
    .peak_detected_i(peak), .det_reset_no(det_reset_no), .busy_o(busy),
    .timeout_o(timeout), .bus(bus)
  );

  typedef struct {
    bit          is_rep;
    logic [63:0] val;
  } ev_t;

  ev_t              sb[$];
  int               total = 0;
  int               bad   = 0;
  int               sbeat = 0;
  int               gap_mode = 0;
  logic [IN_DW-1:0] smp [NB];
  bit               pk  [NB];

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [IN_DW-1:0] rword();
    return IN_DW'($urandom);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: walk absolute search beats n (index = n mod SL); a flag on beat q
  // names sample q-1; hold-off then scans H further samples, stopping after the
  // beat whose index is SL-1.
  function automatic void model_next(input int n0, output bit is_rep,
                                     output logic [63:0] val, output int e);
    int               q;
    int               bi;
    logic [IN_DW-1:0] best;
    logic [IW-1:0]    bix;
    q = -1;
    is_rep = 1'b0;
    val = '0;
    e = NB - 1;
    for (int n = n0; n < NB; n++) begin
      if (pk[n]) begin
        q = n;
        break;
      end
      if (n % SL == SL - 1) begin
        val = 64'(n + 1);
        e = n;
        return;
      end
    end
    if (q < 1) return;
    best = smp[q-1];
    bi = (q - 1) % SL;
    e = q;
    for (int b = q + 1; b <= q + H; b++) begin
      if (smp[b-1] > best) begin
        best = smp[b-1];
        bi = (b - 1) % SL;
      end
      e = b;
      if (b % SL == SL - 1) break;
    end
    bix = IW'(bi);
    is_rep = 1'b1;
    val[IN_DW+IW-1:0] = {best, bix};
  endfunction

  task automatic drv(input bit v, input logic [IN_DW-1:0] d, input bit p);
    bus.s_axis_in_tvalid = v;
    bus.s_axis_in_tdata  = d;
    peak                 = p;
    @(posedge clk);
    #2;
  endtask

  task automatic gap_then_beat(input logic [IN_DW-1:0] d, input bit p);
    int g;
    g = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int i = 0; i < g; i++) drv(1'b0, rword(), rbit());
    drv(1'b1, d, p);
  endtask

  task automatic send(input int n);
    gap_then_beat(smp[n], pk[n]);
    sbeat = n + 1;
  endtask

  task automatic fill(input int maxv);
    for (int n = 0; n < NB; n++) begin
      smp[n] = IN_DW'($urandom_range(0, maxv));
      pk[n]  = 1'b0;
    end
  endtask

  task automatic start_seq();
    start = 1'b1;
    drv(rbit(), rword(), rbit());
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("det_flush_a", 64'(det_reset_no), 64'd0);
    drv(rbit(), rword(), rbit());
    chk("det_flush_b", 64'(det_reset_no), 64'd0);
    drv(rbit(), rword(), rbit());
    chk("det_after_flush", 64'(det_reset_no), 64'd1);
    for (int i = 0; i < WINDOW_LEN + 1; i++) gap_then_beat(rword(), rbit());
    sbeat = 0;
  endtask

  task automatic run(input int max_rep, input int lo, input bit rbeats);
    int          n, e, r, reps, w;
    bit          isr;
    logic [63:0] v;
    ev_t         ev;
    n = 0;
    reps = 0;
    while (reps < max_rep) begin
      model_next(n, isr, v, e);
      ev.is_rep = isr;
      ev.val    = v;
      sb.push_back(ev);
      for (int k = n; k <= e; k++) send(k);
      if (!isr) begin
        drv(1'b0, rword(), 1'b0);
        drv(1'b0, rword(), 1'b0);
        return;
      end
      w = 0;
      while (!bus.m_axis_out_tvalid && w < 10) begin
        drv(1'b0, rword(), 1'b0);
        w++;
      end
      if (!bus.m_axis_out_tvalid) begin
        total++;
        bad++;
        $display("FAIL report_wait tvalid=0 required=1 at %0t", $time);
        return;
      end
      r = 0;
      for (int c = 0; c < lo; c++) begin
        if (rbeats && rbit() && ((e + 1 + r) % SL != SL - 1)) begin
          drv(1'b1, smp[e+1+r], 1'b1);
          r++;
        end else begin
          drv(1'b0, rword(), rbit());
        end
      end
      bus.m_axis_out_tready = 1'b1;
      drv(1'b0, rword(), 1'b1);
      bus.m_axis_out_tready = 1'b0;
      n = e + 1 + r;
      sbeat = n;
      reps++;
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    drv(rbit(), rword(), rbit());
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_tvalid", 64'(bus.m_axis_out_tvalid), 64'd0);
    chk("abort_det", 64'(det_reset_no), 64'd0);
  endtask

  task automatic drain();
    for (int w = 0; w < 20 && sb.size() != 0; w++) drv(1'b0, rword(), 1'b0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: handshakes and timeout pulses pop the scoreboard; a pending
  // report must hold tvalid and tdata until it is taken or aborted.
  logic             prev_tv   = 1'b0;
  logic             prev_free = 1'b1;
  logic             prev_busy = 1'b0;
  logic [63:0]      prev_td   = '0;
  ev_t              got;

  always @(negedge clk) begin
    if (reset) begin
      prev_tv   = 1'b0;
      prev_free = 1'b1;
      prev_busy = 1'b0;
    end else begin
      if (prev_tv && !prev_free) begin
        chk("tvalid_held", 64'(bus.m_axis_out_tvalid), 64'd1);
        chk("tdata_stable", 64'(bus.m_axis_out_tdata), prev_td);
      end
      if (bus.m_axis_out_tvalid && bus.m_axis_out_tready && !abort) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_report tdata=%0h required=none", bus.m_axis_out_tdata);
        end else begin
          got = sb.pop_front();
          chk("event_is_report", 64'd1, 64'(got.is_rep));
          chk("report_tdata", 64'(bus.m_axis_out_tdata), got.val);
        end
      end
      if (timeout) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_timeout beat=%0d required=none", sbeat);
        end else begin
          got = sb.pop_front();
          chk("event_is_timeout", 64'd0, 64'(got.is_rep));
          chk("timeout_beat", 64'(sbeat), got.val);
          chk("timeout_busy_low", 64'(busy), 64'd0);
          chk("busy_before_timeout", 64'(prev_busy), 64'd1);
        end
      end
      prev_tv   = bus.m_axis_out_tvalid;
      prev_td   = 64'(bus.m_axis_out_tdata);
      prev_free = (bus.m_axis_out_tvalid && bus.m_axis_out_tready) || abort;
      prev_busy = busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    peak  = 1'b0;
    bus.s_axis_in_tvalid  = 1'b0;
    bus.s_axis_in_tdata   = '0;
    bus.m_axis_out_tready = 1'b0;
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) drv(1'b0, rword(), rbit());
    reset = 1'b0;
    chk("rst_det", 64'(det_reset_no), 64'd0);
    chk("rst_tvalid", 64'(bus.m_axis_out_tvalid), 64'd0);
    chk("rst_tdata", 64'(bus.m_axis_out_tdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);

    // constant metric, no detection: timeout after SL search beats
    for (int n = 0; n < NB; n++) begin
      smp[n] = IN_DW'(10);
      pk[n]  = 1'b0;
    end
    start_seq();
    run(1, 0, 1'b0);
    chk("t1_busy_idle", 64'(busy), 64'd0);
    drain();

    // refinement to the later, larger sample
    fill(299);
    smp[100] = 500; smp[101] = 400; smp[102] = 900; smp[103] = 300;
    pk[101] = 1'b1;
    start_seq();
    run(1, 3, 1'b0);
    do_abort();
    drain();

    // ties keep the earlier index
    fill(599);
    smp[20] = 700; smp[30] = 700;
    pk[11] = 1'b1;
    start_seq();
    run(1, 2, 1'b0);
    do_abort();
    drain();

    // long backpressure, beats during REPORT, continuous second search
    fill(599);
    pk[51] = 1'b1;
    smp[300] = 999;
    pk[301] = 1'b1;
    start_seq();
    run(2, 50, 1'b1);
    do_abort();
    drain();

    // abort during HOLDOFF
    fill(999);
    pk[40] = 1'b1;
    start_seq();
    for (int n = 0; n <= 45; n++) send(n);
    chk("holdoff_busy", 64'(busy), 64'd1);
    do_abort();
    chk("abort_no_timeout", 64'(timeout), 64'd0);
    drain();
    // abort with a report pending and tready high on the same clock
    start_seq();
    for (int n = 0; n <= 40 + H; n++) send(n);
    chk("report_pending", 64'(bus.m_axis_out_tvalid), 64'd1);
    bus.m_axis_out_tready = 1'b1;
    do_abort();
    bus.m_axis_out_tready = 1'b0;
    drain();
    // reset mid-operation
    start_seq();
    for (int n = 0; n <= 45; n++) send(n);
    reset = 1'b1;
    drv(1'b1, rword(), 1'b1);
    reset = 1'b0;
    chk("midrst_det", 64'(det_reset_no), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_tvalid", 64'(bus.m_axis_out_tvalid), 64'd0);
    chk("midrst_tdata", 64'(bus.m_axis_out_tdata), 64'd0);
    chk("midrst_timeout", 64'(timeout), 64'd0);

    // gapped 1-in-3 stream, same data pattern as the refinement case
    gap_mode = 1;
    fill(299);
    smp[100] = 500; smp[101] = 400; smp[102] = 900; smp[103] = 300;
    pk[101] = 1'b1;
    start_seq();
    run(1, 3, 1'b0);
    do_abort();
    drain();
    // detection on the timeout beat wins
    fill(599);
    pk[SL-1] = 1'b1;
    start_seq();
    run(1, 2, 1'b0);
    do_abort();
    drain();

    // randomized: tie-heavy metrics, sparse flags, random gaps and backpressure
    for (int it = 0; it < 6; it++) begin
      gap_mode = int'($urandom_range(0, 2));
      fill(63);
      for (int n = 1; n < NB; n++) pk[n] = ($urandom_range(0, 299) == 0);
      start_seq();
      run(int'($urandom_range(1, 3)), int'($urandom_range(0, 5)), rbit());
      do_abort();
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
